pipe_skid_latch: RTL and testbench

Parametrised pipeline-stage register that generalises the fixed EX/MEM-style latch. It carries an arbitrary-width payload between two pipeline stages with a valid/ready handshake, global stall enable and flush. It can optionally add a second skid entry so that upstream `in_ready` comes only from registered state. It replaces hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) by instantiating one block per stage with the packed stage struct as payload.

---
 rtl/pipe_skid_latch.sv | 134 +++++++++++++
 tb/tb_pipe_skid_latch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_latch.sv
// pipe_skid_latch
// ---------------------------------------------------------------------------
// This is a generic pipeline-stage register with a valid/ready handshake, a
// stall enable and a flush. One instance replaces one hand-written
// inter-stage latch. The payload is normally the packed stage struct.
//
// Parameters
//   WIDTH       payload width in bits (>= 1)
//   SKID        1: two-entry skid mode. in_ready comes only from registered
//                  state.
//               0: single-entry mode. in_ready is combinational on
//                  out_ready.
//   FLUSH_ZERO  1: flush clears the payload registers as well as the valids.
//               0: flush clears only the valids.
//
// Ports
//   CLK        rising-edge clock
//   nRST       synchronous active-low reset. It clears valids and payloads.
//   en         stage enable. When low, the stage freezes and no transfer
//              occurs.
//   flush      drops every held entry at the next edge. It overrides en and
//              both handshakes.
//   in_valid   upstream handshake, input side
//   in_ready   upstream handshake, output side
//   in_data    upstream payload
//   out_valid  downstream handshake, output side. It is high when the head
//              entry is presented.
//   out_ready  downstream handshake, input side
//   out_data   downstream payload (the head entry)
//   occupancy  number of held entries, 0..2
// ---------------------------------------------------------------------------
module pipe_skid_latch #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          SKID       = 1'b1,
  parameter bit          FLUSH_ZERO = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // EMPTY: M invalid. ONE: M valid. FULL: M and S valid (S younger).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stateE;

  stateE            state_p1;
  stateE            stateNext;
  logic [WIDTH-1:0] mData_p1;
  logic [WIDTH-1:0] sData_p1;
  logic             mVld;
  logic             sVld;
  logic             accept;
  logic             drain;

  // ---- stage register: handshake state ----
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_p1 <= EMPTY;
    end else begin
      state_p1 <= stateNext;
    end
  end

  always_comb begin
    stateNext = state_p1;
    if (flush) begin
      stateNext = EMPTY;
    end else if (en) begin
      case (state_p1)
        EMPTY: if (accept) stateNext = ONE;
        ONE: begin
          // Without a skid entry, accept implies drain, so FULL is never
          // reachable.
          if (accept && !drain) stateNext = SKID ? FULL : ONE;
          else if (!accept && drain) stateNext = EMPTY;
        end
        FULL: if (drain) stateNext = ONE;
        default: stateNext = EMPTY;
      endcase
    end
  end

  always_comb begin
    mVld      = (state_p1 != EMPTY);
    sVld      = (state_p1 == FULL);
    out_valid = mVld & en;
    out_data  = mData_p1;
    occupancy = {1'b0, mVld} + {1'b0, sVld};
    // In skid mode, readiness depends only on registered state. This breaks
    // the combinational out_ready -> in_ready path.
    if (SKID) begin
      in_ready = en & ~sVld;
    end else begin
      in_ready = en & (~mVld | out_ready);
    end
    accept = in_valid & in_ready;
    drain  = out_valid & out_ready;
  end

  // ---- stage register: payload ----
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      mData_p1 <= '0;
      sData_p1 <= '0;
    end else if (flush) begin
      if (FLUSH_ZERO) begin
        mData_p1 <= '0;
        sData_p1 <= '0;
      end
    end else if (en) begin
      case (state_p1)
        EMPTY: if (accept) mData_p1 <= in_data;
        ONE: begin
          if (accept && drain) mData_p1 <= in_data;
          else if (accept && SKID) sData_p1 <= in_data;
        end
        FULL: if (drain) mData_p1 <= sData_p1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_latch.sv
module tb_pipe_skid_latch;

  logic        CLK;
  logic        nRST;
  logic        en;
  logic        flush;
  logic        inValid;
  logic [31:0] inData;
  logic        outReady;

  logic        ir1, ov1, ir0, ov0;
  logic [31:0] od1, od0;
  logic [1:0]  oc1, oc0;

  // sel = 0 observes the skid instance (u1); sel = 1 observes the
  // single-entry instance (u0).
  logic        sel;
  logic        obsInReady, obsOutValid;
  logic [31:0] obsOutData;
  logic [1:0]  obsOcc;

  assign obsInReady  = sel ? ir0 : ir1;
  assign obsOutValid = sel ? ov0 : ov1;
  assign obsOutData  = sel ? od0 : od1;
  assign obsOcc      = sel ? oc0 : oc1;

  int          nCmp;
  int          nErr;
  int          stepNo;
  logic [31:0] sb[$];

  pipe_skid_latch #(.WIDTH(32), .SKID(1'b1), .FLUSH_ZERO(1'b1)) u1 (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .in_valid(inValid), .in_ready(ir1), .in_data(inData),
    .out_valid(ov1), .out_ready(outReady), .out_data(od1), .occupancy(oc1)
  );

  pipe_skid_latch #(.WIDTH(32), .SKID(1'b0), .FLUSH_ZERO(1'b0)) u0 (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .in_valid(inValid), .in_ready(ir0), .in_data(inData),
    .out_valid(ov0), .out_ready(outReady), .out_data(od0), .occupancy(oc0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for the sampling edge, then check the handshake/occupancy outputs
  // of the observed instance.
  task automatic sample(input logic eIR, input logic [1:0] eOcc, input logic eOV);
    @(negedge CLK);
    stepNo++;
    check($sformatf("s%0d_in_ready", stepNo), {31'd0, obsInReady}, {31'd0, eIR});
    check($sformatf("s%0d_occupancy", stepNo), {30'd0, obsOcc}, {30'd0, eOcc});
    check($sformatf("s%0d_out_valid", stepNo), {31'd0, obsOutValid}, {31'd0, eOV});
  endtask

  // Scoreboard bookkeeping for the coming edge, then advance past it.
  task automatic advance();
    if (obsOutValid && outReady) begin
      nCmp++;
      assert (sb.size() != 0) else begin
        nErr++;
        $error("FAIL s%0d_sb_underflow: observed data %h expected none", stepNo, obsOutData);
      end
      if (sb.size() != 0) check($sformatf("s%0d_sb_data", stepNo), obsOutData, sb.pop_front());
    end
    if (inValid && obsInReady) sb.push_back(inData);
    if (flush || !nRST) sb.delete();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nCmp = 0; nErr = 0; stepNo = 0; sel = 1'b0;
    nRST = 1'b0; en = 1'b1; flush = 1'b0;
    inValid = 1'b0; inData = 32'd0; outReady = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // reset state, both instances (in_ready follows en)
    sample(1'b1, 2'd0, 1'b0);
    check("rst_u1_out_data", od1, 32'd0);
    check("rst_u0_in_ready", {31'd0, ir0}, 32'd1);
    check("rst_u0_out_valid", {31'd0, ov0}, 32'd0);
    check("rst_u0_occupancy", {30'd0, oc0}, 32'd0);
    check("rst_u0_out_data", od0, 32'd0);
    nRST = 1'b1;
    advance();

    // streaming on the skid instance
    inValid = 1'b1; inData = 32'h1; outReady = 1'b1;
    sample(1'b1, 2'd0, 1'b0); advance();
    inData = 32'h2;
    sample(1'b1, 2'd1, 1'b1); advance();
    inData = 32'h3;
    sample(1'b1, 2'd1, 1'b1); advance();
    inValid = 1'b0;
    sample(1'b1, 2'd1, 1'b1); advance();
    sample(1'b1, 2'd0, 1'b0); advance();

    // skid absorb: one downstream stall during 0xB
    inValid = 1'b1; inData = 32'hA; outReady = 1'b1;
    sample(1'b1, 2'd0, 1'b0); advance();
    inData = 32'hB; outReady = 1'b0;
    sample(1'b1, 2'd1, 1'b1); advance();
    inData = 32'hC; outReady = 1'b1;
    sample(1'b0, 2'd2, 1'b1); advance();
    sample(1'b1, 2'd1, 1'b1); advance();
    inValid = 1'b0;
    sample(1'b1, 2'd1, 1'b1); advance();
    sample(1'b1, 2'd0, 1'b0); advance();

    // stall with 0x55 held
    inValid = 1'b1; inData = 32'h55; outReady = 1'b0;
    sample(1'b1, 2'd0, 1'b0); advance();
    inValid = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample(1'b0, 2'd1, 1'b0);
      check("stall_out_data", od1, 32'h55);
      advance();
    end
    en = 1'b1; outReady = 1'b1;
    sample(1'b1, 2'd1, 1'b1); advance();
    sample(1'b1, 2'd0, 1'b0); advance();

    // flush in FULL, zeroing payload; 0x77 offered alongside
    inValid = 1'b1; inData = 32'h10; outReady = 1'b0;
    sample(1'b1, 2'd0, 1'b0); advance();
    inData = 32'h20;
    sample(1'b1, 2'd1, 1'b1); advance();
    inData = 32'h77; flush = 1'b1;
    sample(1'b0, 2'd2, 1'b1); advance();
    flush = 1'b0; inValid = 1'b0;
    sample(1'b1, 2'd0, 1'b0);
    check("flushz_out_data", od1, 32'd0);
    advance();

    // flush in ONE drops the payload accepted in the flush cycle
    inValid = 1'b1; inData = 32'h31; outReady = 1'b0;
    sample(1'b1, 2'd0, 1'b0); advance();
    inData = 32'h66; flush = 1'b1;
    sample(1'b1, 2'd1, 1'b1); advance();
    flush = 1'b0; inData = 32'h42; outReady = 1'b1;
    sample(1'b1, 2'd0, 1'b0);
    check("flush1_out_data", od1, 32'd0);
    advance();
    inValid = 1'b0;
    sample(1'b1, 2'd1, 1'b1); advance();

    // reset mid-stream while FULL and flushing
    inValid = 1'b1; inData = 32'h81; outReady = 1'b0;
    sample(1'b1, 2'd0, 1'b0); advance();
    inData = 32'h82;
    sample(1'b1, 2'd1, 1'b1); advance();
    nRST = 1'b0; flush = 1'b1; inData = 32'h83;
    sample(1'b0, 2'd2, 1'b1); advance();
    nRST = 1'b1; flush = 1'b0; inData = 32'h91; outReady = 1'b1;
    sample(1'b1, 2'd0, 1'b0);
    check("rstmid_out_data", od1, 32'd0);
    advance();
    inValid = 1'b0;
    sample(1'b1, 2'd1, 1'b1); advance();

    // single-entry instance, FLUSH_ZERO=0
    sel = 1'b1; nRST = 1'b0; outReady = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    sb.delete();
    inValid = 1'b1; inData = 32'h5A;
    sample(1'b1, 2'd0, 1'b0); advance();
    inData = 32'h5B;
    sample(1'b0, 2'd1, 1'b1);
    outReady = 1'b1;
    #1;
    check("nskid_comb_in_ready", {31'd0, ir0}, 32'd1);
    advance();
    inValid = 1'b0; outReady = 1'b0; flush = 1'b1;
    sample(1'b0, 2'd1, 1'b1);
    check("nskid_head", od0, 32'h5B);
    advance();
    flush = 1'b0;
    sample(1'b1, 2'd0, 1'b0);
    check("flushnz_out_data", od0, 32'h5B);
    advance();

    // single-entry streaming at full rate
    inValid = 1'b1; inData = 32'h61; outReady = 1'b1;
    sample(1'b1, 2'd0, 1'b0); advance();
    inData = 32'h62;
    sample(1'b1, 2'd1, 1'b1); advance();
    inValid = 1'b0;
    sample(1'b1, 2'd1, 1'b1); advance();
    sample(1'b1, 2'd0, 1'b0); advance();

    check("sb_leftover", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
